// File: rtl/tx_mod_pkg.sv
// Shared constants for the BPSK link: oversampling, RRC taps (also used by the receive filter), PRBS9 setup.
package tx_mod_pkg;
  localparam int OS        = 4;
  localparam int LENGTH    = 24;
  localparam int NSYM      = LENGTH / OS;
  localparam int COEF_BITS = 8;
  localparam int IDX_W     = $clog2(LENGTH);

  typedef logic signed [COEF_BITS-1:0] coef_t;

  localparam coef_t COEF [0:LENGTH-1] = '{
    8'h00, 8'hfe, 8'hff, 8'h00, 8'h02, 8'h00, 8'hfb, 8'hf5,
    8'hf9, 8'h0a, 8'h25, 8'h3e, 8'h48, 8'h3e, 8'h25, 8'h0a,
    8'hf9, 8'hf5, 8'hfb, 8'h00, 8'h02, 8'h00, 8'hff, 8'hfe
  };

  // x^9 + x^5 + 1, shifted left, output taken from the MSB
  localparam int                  PRBS_LEN    = 9;
  localparam int                  PRBS_TAP_HI = 8;
  localparam int                  PRBS_TAP_LO = 4;
  localparam logic [PRBS_LEN-1:0] PRBS_SEED   = 9'h1AA;

  function automatic coef_t coef_at(input logic [IDX_W-1:0] idx);
    return COEF[idx];
  endfunction
endpackage

// File: rtl/tx_mod_prbs9.sv
// PRBS9 bit source for the transmitter; o_bit is valid now, i_step advances it one bit per clock.
module prbs9_gen
  import tx_mod_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_step,
  output logic o_bit
);
  logic [PRBS_LEN-1:0] s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= PRBS_SEED;
    end else if (i_step) begin
      s <= {s[PRBS_LEN-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    end
  end

  assign o_bit = s[PRBS_TAP_HI];
endmodule

// File: rtl/tx_mod.sv
// BPSK polyphase RRC pulse shaper, 2 enabled edges from bit to its first sample; i_enable low freezes all state.
// Build option TX_PRBS_EN: bits come from an internal PRBS9 instead of i_bit.
module tx_mod
  import tx_mod_pkg::*;
#(
  parameter int OUT_BITS  = 12,
  parameter int COEF_BITS = tx_mod_pkg::COEF_BITS,
  parameter int LENGTH    = tx_mod_pkg::LENGTH,
  parameter int OS        = tx_mod_pkg::OS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic                i_bit,
  output logic                o_bit_req,
  output logic [OUT_BITS-1:0] o_tx,
  output logic [1:0]          o_phase,
  output logic                o_valid
);
  localparam int NS = LENGTH / OS;
  localparam int PW = $clog2(OS);
  localparam int SW = COEF_BITS + 3;

  logic [PW-1:0] phase_cnt;
  logic [PW-1:0] ph_q;
  logic [NS-1:0] sym;
  logic [NS-1:0] sym_vld;
  logic          bit_in;

  assign o_bit_req = i_enable & (phase_cnt == '0);

`ifdef TX_PRBS_EN
  logic unused_i_bit;
  assign unused_i_bit = i_bit;

  prbs9_gen u_prbs (
    .clk    (clk),
    .rst    (rst),
    .i_step (o_bit_req),
    .o_bit  (bit_in)
  );
`else
  assign bit_in = i_bit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_cnt <= '0;
      ph_q      <= '0;
      sym       <= '0;
      sym_vld   <= '0;
    end else if (i_enable) begin
      phase_cnt <= (phase_cnt == PW'(OS - 1)) ? '0 : phase_cnt + 1'b1;
      ph_q      <= phase_cnt;
      if (phase_cnt == '0) begin
        sym     <= {sym[NS-2:0], bit_in};
        sym_vld <= {sym_vld[NS-2:0], 1'b1};
      end
    end
  end

  // Empty symbol slots contribute nothing, so start-up ramps in cleanly.
  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] tap;
  coef_t                c;

  always_comb begin
    acc = '0;
    tap = '0;
    c   = '0;
    for (int k = 0; k < NS; k++) begin
      c   = coef_at(IDX_W'(int'(ph_q) + OS * k));
      tap = {{(SW - COEF_BITS){c[COEF_BITS-1]}}, c};
      if (sym_vld[k]) begin
        acc = sym[k] ? acc + tap : acc - tap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_tx    <= '0;
      o_phase <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_enable;
      if (i_enable) begin
        o_tx    <= {{(OUT_BITS - SW){acc[SW-1]}}, acc};
        o_phase <= ph_q;
      end
    end
  end
endmodule

// File: tb/tb_tx_mod.sv
// Scoreboard bench for tx_mod: reference is the direct convolution of the upsampled +/-1 stream with h[].
`timescale 1ns/1ps
module tb_tx_mod;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_bit = 1'b0;
  logic        o_bit_req;
  logic [11:0] o_tx;
  logic [1:0]  o_phase;
  logic        o_valid;

  tx_mod dut (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (i_enable),
    .i_bit     (i_bit),
    .o_bit_req (o_bit_req),
    .o_tx      (o_tx),
    .o_phase   (o_phase),
    .o_valid   (o_valid)
  );

  always #5 clk = ~clk;

  int h [24] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62,
                 72, 62, 37, 10, -7, -11, -5, 0, 2, 0, -1, -2};

  typedef struct { int tx; int ph; } exp_t;
  exp_t q[$];
  int   bits[$];
  int   n_edges = 0;
  int   errors  = 0;
  int   checks  = 0;
  logic [8:0] seed = 9'h1AA;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Shaped sample at upsampled time m: sum of h[j] * x_up[m-j], symbols sit every OS samples.
  function automatic int ref_sample(input int m);
    int s = 0;
    for (int j = 0; j < 24; j++) begin
      int d = m - j;
      if (d >= 0 && d % 4 == 0) s += (bits[d/4] != 0) ? h[j] : -h[j];
    end
    return s;
  endfunction

  task automatic model_reset();
    n_edges = 0;
    bits.delete();
    q.delete();
  endtask

  task automatic step(input logic en, input logic b);
    exp_t e;
    int   nb;
    int   i;
    @(posedge clk);
    #2;
    i_enable = en;
    i_bit    = b;
    #1;
    chk("bit_req", int'(o_bit_req), (en && (n_edges % 4 == 0)) ? 1 : 0);
    if (en) begin
      e.tx = (n_edges == 0) ? 0 : ref_sample(n_edges - 1);
      e.ph = (n_edges == 0) ? 0 : (n_edges - 1) % 4;
      q.push_back(e);
      if (n_edges % 4 == 0) begin
        i = bits.size();
`ifdef TX_PRBS_EN
        nb = (i < 9) ? int'(seed[8-i]) : (bits[i-9] ^ bits[i-5]);
`else
        nb = int'(b);
`endif
        bits.push_back(nb);
      end
      n_edges++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst      = 1'b0;
    i_enable = 1'b0;
    model_reset();
    #1;
    chk("rst_tx", int'(o_tx), 0);
    chk("rst_phase", int'(o_phase), 0);
    chk("rst_valid", int'(o_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic run_to_phase(input int p);
    while (n_edges % 4 != p) step(1'b1, 1'($urandom));
  endtask

  // Monitor: pop one expectation per valid sample; when not valid, outputs must hold.
  initial begin
    exp_t e;
    int   last_tx = 0;
    int   last_ph = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("inrst_tx", int'(o_tx), 0);
        chk("inrst_valid", int'(o_valid), 0);
        last_tx = 0;
        last_ph = 0;
      end else if (o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("tx", int'($signed(o_tx)), e.tx);
          chk("phase", int'(o_phase), e.ph);
        end
        last_tx = int'($signed(o_tx));
        last_ph = int'(o_phase);
      end else begin
        chk("hold_tx", int'($signed(o_tx)), last_tx);
        chk("hold_phase", int'(o_phase), last_ph);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;

    // first bit 1 from an empty filter
    step(1'b1, 1'b1);
    repeat (11) step(1'b1, 1'($urandom));

    repeat (40) step(1'b1, 1'b1);
    repeat (40) step(1'b1, 1'b0);

    // stall mid-symbol, then stall on a bit-request cycle
    run_to_phase(2);
    repeat (3) step(1'b0, 1'($urandom));
    repeat (8) step(1'b1, 1'($urandom));
    run_to_phase(0);
    repeat (3) step(1'b0, 1'($urandom));
    repeat (8) step(1'b1, 1'($urandom));

    repeat (400) step(($urandom_range(0, 3) != 0), 1'($urandom));

    run_to_phase(2);
    do_reset();
    step(1'b1, 1'b1);
    repeat (15) step(1'b1, 1'($urandom));

    repeat (3) step(1'b0, 1'b0);
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
